ring_osc_freq_meter: RTL and testbench
======================================

// Module: ring_osc_freq_meter
// PURPOSE
//  Multi-channel frequency meter for on-die ring oscillators.
//  - Counts rising edges of one selected ring output over a programmable gate window of 2^g clk cycles.
//  - The count is returned on a valid/ready result port.
//  - Successor to the single-ring / fixed-divider probe: many rings, runtime gate length,
//    one-shot or continuous mode, and saturation reporting.
//  - Ring inputs are asynchronous. Each ring is pre-divided upstream so that f_ring < f_clk/4.
// PARAMETERS
//  NUM_CH         4   number of ring inputs
//  CH_W           2   width of chan_sel (>= clog2(NUM_CH))
//  CNT_W          16  width of the result / edge counter
//  MAX_GATE_LOG2  20  largest allowed gate exponent
//  GATE_SEL_W     5   width of gate_log2 (>= clog2(MAX_GATE_LOG2+1))
//  SYNC_STAGES    2   synchronizer flops per channel (>= 2)
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous reset, active high
//  ring_in       in   NUM_CH      async ring oscillator outputs
//  start         in   1           one-cycle request; sampled only in IDLE
//  cont_mode     in   1           1 = re-measure automatically after each accepted result
//  chan_sel      in   CH_W        channel to measure; latched at start
//  gate_log2     in   GATE_SEL_W  gate = 2^gate_log2 clk cycles; latched at start
//  result        out  CNT_W       rising-edge count of the last window
//  result_valid  out  1           result held valid until accepted
//  result_ready  in   1           consumer accepts when valid & ready
//  overflow      out  1           last result saturated
//  busy          out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE; result=0; result_valid=0; overflow=0; busy=0.
//   - All synchronizer, edge and gate registers cleared.
//   - Reset in any state discards the measurement in progress.
//  Front end:
//   - Every channel passes through SYNC_STAGES flops, then the selected channel goes through a mux.
//   - rise = s & ~s_d (one-cycle pulse).
//  State machine:
//   - IDLE:
//     - start=1 & chan_sel<NUM_CH: latch ch, g=min(gate_log2, MAX_GATE_LOG2); go to SETTLE.
//     - start with chan_sel>=NUM_CH is ignored; the block stays in IDLE.
//   - SETTLE:
//     - Holds for SYNC_STAGES+1 cycles to flush stale edges.
//     - Clears the edge counter; loads the gate counter with 2^g-1; go to COUNT.
//   - COUNT:
//     - Each rise increments the edge counter, saturating at all-ones; sat flag set on a clipped increment.
//     - The gate counter decrements every cycle. In the cycle it reads 0, that cycle's rise is still counted.
//     - result<=final count and overflow<=sat are registered on the next edge; go to DONE.
//     - Window is exactly 2^g cycles; COUNT->DONE latency is 1 cycle.
//   - DONE:
//     - result_valid=1; result and overflow are stable while valid.
//     - On valid&ready, result_valid drops the next cycle.
//     - After accept with cont_mode=1: go to COUNT, reload the gate counter, clear the edge counter.
//       Same ch and g; no SETTLE; the dead time between windows is 1 cycle.
//     - After accept with cont_mode=0: go to IDLE.
//  Input sampling and holds:
//   - start, chan_sel and gate_log2 are ignored outside IDLE; cont_mode is sampled at accept.
//   - result and overflow hold their last values in IDLE (cleared only by rst).
//   - busy=0 exactly when the state is IDLE.
//  Measurement bounds:
//   - Expected result = f_ring * 2^g / f_clk, within +/-1.
//   - Max representable edge count is 2^(g-1), because of the synchronizer.
// STRUCTURE
//  - Shared defines header: state encoding (IDLE/SETTLE/COUNT/DONE, 2 bits), clog2 helper,
//    default widths.
//  - Sub-module sync_edge_det (SYNC_STAGES flops + rising-edge pulse), instantiated per channel.
//  - Top level holds the mux, FSM, gate counter, saturating edge counter and result register.
// TESTING (NUM_CH=4, CNT_W=16, MAX_GATE_LOG2=12 unless stated)
//  1. ring_in[1] period 8 clk, chan_sel=1, gate_log2=6, start
//     -> result=8 (+/-1), overflow=0, valid 64+SETTLE+1 cycles after start.
//  2. CNT_W=6 instance, ring period 4 clk, gate_log2=10
//     -> result=63, overflow=1.
//  3. Hold result_ready=0 for 20 cycles in DONE; pulse start and change chan_sel
//     -> valid stays 1, result stable, no new measurement.
//  4. cont_mode=1, ring period 16, gate_log2=8, ready=1
//     -> back-to-back results of 16 (+/-1), 1 cycle dead time, busy never drops.
//  5. rst=1 mid-COUNT
//     -> next cycle result=0, valid=0, busy=0, IDLE; a new start measures correctly.
//  6. start with chan_sel=... not applicable at CH_W=2; use NUM_CH=3, chan_sel=3
//     -> ignored, busy stays 0; gate_log2=31 clamps to a 4096-cycle window.

Source files
------------

// File: rtl/ring_osc_freq_meter_pkg.sv
// rtl/ring_osc_freq_meter_pkg.sv - shared state encoding, default widths and clog2 helper
// Purpose: common definitions for the ring oscillator frequency meter.
// Ports: none (package).
package ring_osc_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_CH_W          = 2;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_MAX_GATE_LOG2 = 20;
  localparam int DEF_GATE_SEL_W    = 5;
  localparam int DEF_SYNC_STAGES   = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_osc_freq_meter_if.sv
// rtl/ring_osc_freq_meter_if.sv - control and result handshake bundle
// Purpose: groups the measurement request and valid/ready result signals.
// Ports (signals):
//   start, cont_mode, chan_sel, gate_log2 : request side (master drives)
//   result, result_valid, overflow, busy  : result side (slave drives)
//   result_ready                          : consumer accept (master drives)
interface ring_osc_freq_meter_if
  import ring_osc_freq_meter_pkg::*;
#(
  parameter int CH_W       = DEF_CH_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_SEL_W = DEF_GATE_SEL_W
) ();

  logic                  start;
  logic                  cont_mode;
  logic [CH_W-1:0]       chan_sel;
  logic [GATE_SEL_W-1:0] gate_log2;
  logic [CNT_W-1:0]      result;
  logic                  result_valid;
  logic                  result_ready;
  logic                  overflow;
  logic                  busy;

  modport master (
    output start, cont_mode, chan_sel, gate_log2, result_ready,
    input  result, result_valid, overflow, busy
  );

  modport slave (
    input  start, cont_mode, chan_sel, gate_log2, result_ready,
    output result, result_valid, overflow, busy
  );

endinterface

// File: rtl/ring_osc_freq_meter_sync_edge_det.sv
// rtl/ring_osc_freq_meter_sync_edge_det.sv - per-channel synchronizer and rising-edge pulse
// Purpose: brings one asynchronous ring output into the clk domain and flags rising edges.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active high
//   async_in in  asynchronous ring output
//   rise     out one-cycle pulse on a synchronized rising edge
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - multi-channel ring oscillator frequency meter
// Purpose: counts rising edges of a selected ring over a 2^g clk-cycle gate window.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active high
//   ring_in in  asynchronous ring oscillator outputs (NUM_CH)
//   bus     slave modport: start/cont_mode/chan_sel/gate_log2 request,
//           result/result_valid/result_ready/overflow handshake, busy status
module ring_osc_freq_meter
  import ring_osc_freq_meter_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CH_W          = DEF_CH_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int MAX_GATE_LOG2 = DEF_MAX_GATE_LOG2,
  parameter int GATE_SEL_W    = DEF_GATE_SEL_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ring_in,
  ring_osc_freq_meter_if.slave bus
);

  localparam int GW    = MAX_GATE_LOG2;
  localparam int SW    = (clog2(SYNC_STAGES + 1) < 1) ? 1 : clog2(SYNC_STAGES + 1);
  localparam int PAD_W = 1 << CH_W;

  localparam logic [CH_W:0]       NUM_CH_V  = (CH_W + 1)'(NUM_CH);
  localparam logic [GATE_SEL_W-1:0] MAX_G   = GATE_SEL_W'(MAX_GATE_LOG2);
  localparam logic [GW:0]         ONE_G     = (GW + 1)'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [GW-1:0]       GATE_ONE  = GW'(1);
  localparam logic [SW-1:0]       SETTLE_LD = SW'(SYNC_STAGES);
  localparam logic [SW-1:0]       SETTLE_ONE = SW'(1);

  state_t state_q;
  state_t state_d;

  logic [CH_W-1:0]       ch_q;
  logic [GATE_SEL_W-1:0] g_q;
  logic [SW-1:0]         settle_q;
  logic [GW-1:0]         gate_q;
  logic [CNT_W-1:0]      edge_q;
  logic                  sat_q;
  logic [CNT_W-1:0]      result_q;
  logic                  ovf_q;

  logic [NUM_CH-1:0]     rise_vec;
  logic [PAD_W-1:0]      rise_pad;
  logic                  rise_sel;

  logic                  start_ok;
  logic [GATE_SEL_W-1:0] g_in;
  logic [GW:0]           one_sh;
  logic [GW:0]           gate_load_full;
  logic [GW-1:0]         gate_load;
  logic                  settle_end;
  logic                  window_end;
  logic                  accept;
  logic                  edge_full;
  logic [CNT_W-1:0]      next_edge;
  logic                  next_sat;
  logic                  busy_c;
  logic                  valid_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (ring_in[i]),
      .rise     (rise_vec[i])
    );
  end

  // Zero-padded so any chan_sel code indexes a defined bit.
  assign rise_pad = PAD_W'(rise_vec);
  assign rise_sel = rise_pad[ch_q];

  assign start_ok = bus.start && ({1'b0, bus.chan_sel} < NUM_CH_V);
  assign g_in     = (bus.gate_log2 > MAX_G) ? MAX_G : bus.gate_log2;

  // Gate counter runs 2^g-1 down to 0 inclusive, giving exactly 2^g cycles.
  assign one_sh         = ONE_G << g_q;
  assign gate_load_full = one_sh - ONE_G;
  assign gate_load      = gate_load_full[GW-1:0];

  assign settle_end = (state_q == ST_SETTLE) && (settle_q == '0);
  assign window_end = (state_q == ST_COUNT) && (gate_q == '0);
  assign accept     = (state_q == ST_DONE) && bus.result_ready;

  assign edge_full = (edge_q == '1);
  assign next_edge = (rise_sel && !edge_full) ? edge_q + CNT_ONE : edge_q;
  assign next_sat  = sat_q | (rise_sel & edge_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok)   state_d = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_d = ST_COUNT;
      ST_COUNT:  if (window_end) state_d = ST_DONE;
      ST_DONE:   if (accept)     state_d = bus.cont_mode ? ST_COUNT : ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = 1'b1;
    valid_c = 1'b0;
    case (state_q)
      ST_IDLE: busy_c  = 1'b0;
      ST_DONE: valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      g_q      <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            ch_q     <= bus.chan_sel;
            g_q      <= g_in;
            settle_q <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          // Lets edges from the previously selected ring drain out of the synchronizer.
          if (settle_end) begin
            edge_q <= '0;
            sat_q  <= 1'b0;
            gate_q <= gate_load;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end
        ST_COUNT: begin
          edge_q <= next_edge;
          sat_q  <= next_sat;
          gate_q <= gate_q - GATE_ONE;
          if (window_end) begin
            // The final cycle's rise is folded in here, not lost.
            result_q <= next_edge;
            ovf_q    <= next_sat;
          end
        end
        ST_DONE: begin
          if (accept && bus.cont_mode) begin
            edge_q <= '0;
            sat_q  <= 1'b0;
            gate_q <= gate_load;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.overflow     = ovf_q;
  assign bus.result_valid = valid_c;
  assign bus.busy         = busy_c;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb/tb_ring_osc_freq_meter.sv - self-checking bench for ring_osc_freq_meter
module tb_ring_osc_freq_meter;

  localparam int SETTLE_CYC = 3;

  typedef struct {
    int res;
    int tol;
    bit ovf;
    int lat;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0 = 1'b0;
  logic r1 = 1'b0;
  logic r2 = 1'b0;
  logic r3 = 1'b0;
  logic [3:0] ring;

  always #5 clk = ~clk;

  // Ring periods in clk cycles: ch0 16, ch1 8, ch2 4, ch3 6; edges never on a clk edge.
  initial begin #3; forever #80 r0 = ~r0; end
  initial begin #3; forever #40 r1 = ~r1; end
  initial begin #3; forever #20 r2 = ~r2; end
  initial begin #3; forever #30 r3 = ~r3; end
  assign ring = {r3, r2, r1, r0};

  ring_osc_freq_meter_if #(.CH_W(2), .CNT_W(16), .GATE_SEL_W(5)) bus_a ();
  ring_osc_freq_meter_if #(.CH_W(2), .CNT_W(6),  .GATE_SEL_W(5)) bus_b ();

  ring_osc_freq_meter #(
    .NUM_CH(4), .CH_W(2), .CNT_W(16), .MAX_GATE_LOG2(12), .GATE_SEL_W(5), .SYNC_STAGES(2)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .ring_in (ring),
    .bus     (bus_a)
  );

  ring_osc_freq_meter #(
    .NUM_CH(3), .CH_W(2), .CNT_W(6), .MAX_GATE_LOG2(12), .GATE_SEL_W(5), .SYNC_STAGES(2)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .ring_in (ring[2:0]),
    .bus     (bus_b)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input longint obs, input longint exp, input int tol);
    bit in_range;
    in_range = (obs >= exp - tol) && (obs <= exp + tol);
    n_cmp++;
    assert (in_range === 1'b1) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic sb_check(input string tag, input bit got_valid, input longint obs_res,
                          input bit obs_ovf, input int obs_lat);
    exp_t e;
    check({tag, "_valid"}, got_valid, 1);
    check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_tol({tag, "_result"}, obs_res, e.res, e.tol);
    check({tag, "_overflow"}, obs_ovf, e.ovf);
    if (e.lat >= 0) check({tag, "_latency"}, obs_lat, e.lat);
  endtask

  task automatic start_and_wait_a(input int budget, output int cycles);
    bus_a.start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      cycles++;
    end while (bus_a.result_valid !== 1'b1 && cycles < budget);
  endtask

  task automatic start_and_wait_b(input int budget, output int cycles);
    bus_b.start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      bus_b.start = 1'b0;
      cycles++;
    end while (bus_b.result_valid !== 1'b1 && cycles < budget);
  endtask

  task automatic accept_a();
    bus_a.result_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.result_ready = 1'b0;
  endtask

  task automatic accept_b();
    bus_b.result_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.result_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit busy_ok;

    bus_a.start = 0; bus_a.cont_mode = 0; bus_a.chan_sel = 0; bus_a.gate_log2 = 0; bus_a.result_ready = 0;
    bus_b.start = 0; bus_b.cont_mode = 0; bus_b.chan_sel = 0; bus_b.gate_log2 = 0; bus_b.result_ready = 0;

    repeat (4) @(posedge clk);
    #1;
    check("rst_a_result", bus_a.result, 0);
    check("rst_a_valid", bus_a.result_valid, 0);
    check("rst_a_overflow", bus_a.overflow, 0);
    check("rst_a_busy", bus_a.busy, 0);
    check("rst_b_result", bus_b.result, 0);
    check("rst_b_busy", bus_b.busy, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single window: ring period 8, 64-cycle gate.
    bus_a.chan_sel = 2'd1; bus_a.gate_log2 = 5'd6;
    sb_q.push_back('{res: 8, tol: 1, ovf: 1'b0, lat: 64 + SETTLE_CYC + 1});
    start_and_wait_a(200, cyc);
    sb_check("t1", bus_a.result_valid, bus_a.result, bus_a.overflow, cyc);

    // Stall in DONE; start and chan_sel changes must be ignored.
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin bus_a.start = 1'b1; bus_a.chan_sel = 2'd2; end
      if (i == 6) bus_a.start = 1'b0;
      @(posedge clk); #1;
      check("t3_hold_valid", bus_a.result_valid, 1);
      check("t3_hold_result", bus_a.result, 8);
    end
    accept_a();
    check("t3_valid_drop", bus_a.result_valid, 0);
    check("t3_idle_busy", bus_a.busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_no_new_meas", bus_a.busy, 0);

    // Continuous mode: ring period 16, 256-cycle gate.
    bus_a.chan_sel = 2'd0; bus_a.gate_log2 = 5'd8; bus_a.cont_mode = 1'b1; bus_a.result_ready = 1'b1;
    sb_q.push_back('{res: 16, tol: 1, ovf: 1'b0, lat: 256 + SETTLE_CYC + 1});
    sb_q.push_back('{res: 16, tol: 1, ovf: 1'b0, lat: 256 + 1});
    sb_q.push_back('{res: 16, tol: 1, ovf: 1'b0, lat: 256 + 1});
    start_and_wait_a(400, cyc);
    sb_check("t4_w0", bus_a.result_valid, bus_a.result, bus_a.overflow, cyc);
    busy_ok = 1'b1;
    for (int k = 1; k < 3; k++) begin
      if (k == 2) busy_ok = busy_ok;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
        if (bus_a.busy !== 1'b1) busy_ok = 1'b0;
      end while (bus_a.result_valid !== 1'b1 && cyc < 400);
      if (k == 2) bus_a.cont_mode = 1'b0;
      sb_check($sformatf("t4_w%0d", k), bus_a.result_valid, bus_a.result, bus_a.overflow, cyc);
    end
    check("t4_busy_never_dropped", busy_ok, 1);
    @(posedge clk); #1;
    bus_a.result_ready = 1'b0;
    check("t4_stop_busy", bus_a.busy, 0);
    check("t4_stop_valid", bus_a.result_valid, 0);

    // Reset in the middle of COUNT discards the window.
    bus_a.chan_sel = 2'd1; bus_a.gate_log2 = 5'd6;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t5_counting_busy", bus_a.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_result", bus_a.result, 0);
    check("t5_rst_valid", bus_a.result_valid, 0);
    check("t5_rst_busy", bus_a.busy, 0);
    check("t5_rst_overflow", bus_a.overflow, 0);
    sb_q.push_back('{res: 8, tol: 1, ovf: 1'b0, lat: 64 + SETTLE_CYC + 1});
    start_and_wait_a(200, cyc);
    sb_check("t5_after", bus_a.result_valid, bus_a.result, bus_a.overflow, cyc);
    accept_a();

    // Three-channel instance: out-of-range channel is ignored.
    bus_b.chan_sel = 2'd3; bus_b.gate_log2 = 5'd4;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    check("t6_bad_ch_busy0", bus_b.busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_bad_ch_busy1", bus_b.busy, 0);
    check("t6_bad_ch_valid", bus_b.result_valid, 0);

    // 6-bit counter saturates: 256 edges in a 1024-cycle gate.
    bus_b.chan_sel = 2'd2; bus_b.gate_log2 = 5'd10;
    sb_q.push_back('{res: 63, tol: 0, ovf: 1'b1, lat: 1024 + SETTLE_CYC + 1});
    start_and_wait_b(1200, cyc);
    sb_check("t2_sat", bus_b.result_valid, bus_b.result, bus_b.overflow, cyc);
    accept_b();
    check("t2_idle", bus_b.busy, 0);

    // gate_log2=31 clamps to 12: 4096-cycle window.
    bus_b.chan_sel = 2'd0; bus_b.gate_log2 = 5'd31;
    sb_q.push_back('{res: 63, tol: 0, ovf: 1'b1, lat: 4096 + SETTLE_CYC + 1});
    start_and_wait_b(4500, cyc);
    sb_check("t6_clamp", bus_b.result_valid, bus_b.result, bus_b.overflow, cyc);
    accept_b();
    check("t6_idle", bus_b.busy, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
